// File: rtl/sfu_writeback_if.sv
`default_nettype none
// ============================================================================
// Module   : sfu_writeback_if
// Brief    : Output-SRAM write channel (valid/ready) between the SFU
//            writeback block and the output SRAM write port.
// Revision : 1.0  initial release
// ============================================================================
interface sfu_writeback_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 128
);
    logic              wen;
    logic              ready;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    // Writeback side drives the word, SRAM side returns ready
    modport master (output wen, addr, data, input ready);
    modport slave  (input wen, addr, data, output ready);
endinterface
`default_nettype wire

// File: rtl/sfu_writeback.sv
`default_nettype none
// ============================================================================
// Module   : sfu_writeback
// Brief    : Drains the SFU accumulation bank one position at a time,
//            applies optional ReLU and writes each position as one packed
//            word to the output SRAM, then requests a bank clear.
// Revision : 1.0  initial release
// ============================================================================
module sfu_writeback #(
    parameter int NUM_CH  = 8,
    parameter int NUM_POS = 16,
    parameter int PSUM_BW = 16,
    parameter int ADDR_W  = 11
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         relu_en,
    input  logic [ADDR_W-1:0]            base_addr,
    output logic [$clog2(NUM_POS)-1:0]   bank_rd_idx,
    input  logic [NUM_CH*PSUM_BW-1:0]    bank_rd_data,
    output logic                         bank_clear,
    sfu_writeback_if.master              sram,
    output logic                         busy,
    output logic                         done
);
    localparam int c_POS_W  = $clog2(NUM_POS);
    localparam int c_DATA_W = NUM_CH * PSUM_BW;
    localparam logic [c_POS_W-1:0] c_LAST_POS = c_POS_W'(NUM_POS - 1);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_READ   = 2'd1;
    localparam logic [1:0] c_S_FLUSH  = 2'd2;
    localparam logic [1:0] c_S_FINISH = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [c_POS_W-1:0]  r_pos;
    logic                r_relu;
    logic [ADDR_W-1:0]   r_base;
    logic                r_valid;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_DATA_W-1:0] r_data;
    logic [c_DATA_W-1:0] w_relu_data;
    logic                w_accept;
    logic                w_load;

    // The output stage can take a new word when empty or when its word leaves
    assign w_accept = r_valid && sram.ready;
    assign w_load   = (r_state == c_S_READ) && (!r_valid || sram.ready);

    // Per-channel ReLU: a set sign bit forces the psum to zero
    for (genvar g = 0; g < NUM_CH; g++) begin : g_relu
        assign w_relu_data[PSUM_BW*g +: PSUM_BW] =
            (r_relu && bank_rd_data[PSUM_BW*g + PSUM_BW - 1]) ? '0
                                                              : bank_rd_data[PSUM_BW*g +: PSUM_BW];
    end

    assign sram.wen  = r_valid;
    assign sram.addr = r_addr;
    assign sram.data = r_data;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; start outside IDLE is dropped, not queued
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE:   if (start) w_next_state = c_S_READ;
            c_S_READ:   if (w_load && (r_pos == c_LAST_POS)) w_next_state = c_S_FLUSH;
            c_S_FLUSH:  if (w_accept) w_next_state = c_S_FINISH;
            c_S_FINISH: w_next_state = c_S_IDLE;
            default:    w_next_state = c_S_IDLE;
        endcase
    end

    // Status outputs; the bank index is parked at 0 outside READ
    always_comb begin
        busy        = (r_state != c_S_IDLE);
        done        = (r_state == c_S_FINISH);
        bank_clear  = (r_state == c_S_FINISH);
        bank_rd_idx = (r_state == c_S_READ) ? r_pos : '0;
    end

    // Datapath: drain configuration, position counter and the output stage
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pos   <= '0;
            r_relu  <= 1'b0;
            r_base  <= '0;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if ((r_state == c_S_IDLE) && start) begin
            r_pos   <= '0;
            r_relu  <= relu_en;
            r_base  <= base_addr;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_addr  <= r_base + ADDR_W'(r_pos);
            r_data  <= w_relu_data;
            r_pos   <= r_pos + 1'b1;
        end else if ((r_state == c_S_FLUSH) && w_accept) begin
            r_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: doc/sfu_writeback.md
# sfu_writeback

Drains the SFU accumulation bank (NUM_CH channels × NUM_POS output positions of signed psums) after a tile finishes accumulating. It reads the bank one position at a time, applies optional ReLU, and writes each position as one packed word to the output SRAM through a valid/ready handshake. When the last word is accepted, it pulses a bank-clear request back to the SFU. It sits between the SFU accumulator bank and the output SRAM write port, on the read side of the bank.

## Interface
Parameters:
- NUM_CH, 8, channels per position (one psum per channel, per SRAM word)
- NUM_POS, 16, output positions held in the bank
- PSUM_BW, 16, signed psum width
- ADDR_W, 11, SRAM address width

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to drain the bank; honoured only in IDLE
- relu_en  in  1  clamp negatives to 0; sampled with start
- base_addr  in  ADDR_W  SRAM address of position 0; sampled with start
- bank_rd_idx  out  $clog2(NUM_POS)  bank position being read
- bank_rd_data  in  NUM_CH*PSUM_BW  combinational bank contents at bank_rd_idx; channel i at [PSUM_BW*i +: PSUM_BW]
- bank_clear  out  1  one-cycle pulse; the SFU zeroes the bank and its counter
- sram_wen  out  1  write valid
- sram_ready  in  1  SRAM accepts the word when sram_wen && sram_ready
- sram_addr  out  ADDR_W  write address
- sram_data  out  NUM_CH*PSUM_BW  write data, same packing as bank_rd_data
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the drain completes

## Operation
States:
- IDLE: start → READ. Capture relu_en and base_addr, clear pos counter and output stage.
- READ: bank_rd_idx = pos.
  - When the output stage is empty or being accepted this cycle: load the output stage from bank_rd_data (ReLU applied per channel if enabled), set sram_addr = base_addr + pos (mod 2^ADDR_W), and increment pos.
  - After loading pos = NUM_POS-1 → FLUSH.
- FLUSH: hold the last word until it is accepted, then → FINISH.
- FINISH: pulse bank_clear and done for one cycle → IDLE.

Rules:
- ReLU: if relu_en and the psum sign bit is 1, output 0; otherwise the psum passes unchanged. No width change and no saturation.
- Output stage: one register (valid, addr, data). While sram_wen && !sram_ready, sram_addr and sram_data hold stable, and pos and bank_rd_idx do not advance.
- Ordering: positions are written strictly as 0..NUM_POS-1, each exactly once.
- Address arithmetic wraps at 2^ADDR_W with no error signal.
- bank_rd_idx is 0 whenever the block is not in READ.
- start while busy is ignored; it is not queued.

## Timing
- Reset values: all outputs are 0 (sram_wen, bank_clear, done, busy, bank_rd_idx, sram_addr, sram_data). State is IDLE.
- Reset mid-drain aborts immediately. No bank_clear is issued, so the bank contents are preserved for a retry.
- start sampled high at edge 0: busy is high from cycle 1, bank_rd_idx=0 in cycle 1, and the first sram_wen is in cycle 2.
- With sram_ready held high: writes occur in cycles 2..NUM_POS+1, one per cycle. bank_clear and done are high together in cycle NUM_POS+2. busy is low from cycle NUM_POS+3.
- Each cycle of sram_ready low while sram_wen is high adds exactly one cycle to total latency.
- bank_clear is asserted only after the final word is accepted. bank_rd_data is never sampled in the bank_clear cycle.
- start in the same cycle as done is ignored. start in the first IDLE cycle after that is accepted.

## Test plan
- Normal drain: bank[ch][p] = p*8+ch, relu_en=0, base_addr=0x100, ready always high → 16 writes at 0x100..0x10F in cycles 2..17. Word p carries channel values p*8..p*8+7. done and bank_clear pulse in cycle 18.
- ReLU: channel 3 of position 5 = 16'hFF9C (-100), channel 4 = 16'h0064, relu_en=1 → word 5 has channel 3 = 0 and channel 4 = 0x0064. With relu_en=0 the same word carries 0xFF9C unchanged.
- Backpressure: sram_ready low for 3 cycles on write 7 and low on alternate cycles for writes 10-12 → addr/data stable while stalled, no word dropped or duplicated, done delayed by exactly the number of stall cycles.
- Address wrap: base_addr=0x7F8 (ADDR_W=11) → addresses 0x7F8..0x7FF, then 0x000..0x007.
- start while busy at cycle 5 → ignored; exactly 16 writes and one done. Reset asserted at write 9 → all outputs 0 next cycle, no bank_clear. A new start then drains from position 0.
